// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID
// register, honouring branch flush over load-use stall, with a saturating stall counter.
module fetch_stage #(
    parameter int unsigned          REG_WIDTH   = 64,
    parameter int unsigned          REG_COUNT   = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [REG_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned          CNT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [REG_WIDTH-1:0]         branch_target,
    output logic [REG_WIDTH-1:0]         imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_rdata,
    output logic [REG_WIDTH-1:0]         if_id_pc,
    output logic [INSTR_WIDTH-1:0]       if_id_instr,
    output logic                         if_id_valid,
    output logic [$clog2(REG_COUNT)-1:0] if_id_rs1,
    output logic [$clog2(REG_COUNT)-1:0] if_id_rs2,
    output logic [CNT_WIDTH-1:0]         stall_count
);
    localparam int unsigned RS_W = $clog2(REG_COUNT);
    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

    logic [REG_WIDTH-1:0]   pc_q, pc_d;
    logic [REG_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
    logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [RS_W-1:0]        rs1_q, rs1_d, rs2_q, rs2_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // Next-state selection: flush beats stall beats advance.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        cnt_d        = cnt_q;
        if (flush) begin
            pc_d         = {branch_target[REG_WIDTH-1:2], 2'b00};
            ifid_pc_d    = '0;
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            rs1_d        = '0;
            rs2_d        = '0;
        end else if (stall) begin
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            pc_d         = pc_q + REG_WIDTH'(4);
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            // Register fields are pre-decoded so bubbles present zero to the hazard unit.
            rs1_d        = imem_rdata[19:15];
            rs2_d        = imem_rdata[24:20];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            cnt_q        <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_valid = ifid_valid_q;
    assign if_id_rs1   = rs1_q;
    assign if_id_rs2   = rs2_q;
    assign stall_count = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free fetch, load-use stall, flush, flush+stall,
// PC wrap, async reset mid-stall, and counter saturation on a narrow-counter instance.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, stall1, zero1;
    logic [63:0] branch_target, imem_addr, if_id_pc;
    logic [31:0] imem_rdata, if_id_instr;
    logic        if_id_valid;
    logic [4:0]  if_id_rs1, if_id_rs2;
    logic [31:0] stall_count;

    logic [63:0] u1_addr, u1_pc;
    logic [31:0] u1_instr;
    logic        u1_valid;
    logic [4:0]  u1_rs1, u1_rs2;
    logic [1:0]  u1_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(64'h1000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .if_id_rs1(if_id_rs1),
        .if_id_rs2(if_id_rs2), .stall_count(stall_count)
    );

    fetch_stage #(.RESET_PC(64'h0), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall1), .flush(zero1), .branch_target(64'h0),
        .imem_addr(u1_addr), .imem_rdata(32'h0000_0013), .if_id_pc(u1_pc),
        .if_id_instr(u1_instr), .if_id_valid(u1_valid), .if_id_rs1(u1_rs1),
        .if_id_rs2(u1_rs2), .stall_count(u1_cnt)
    );

    function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2);
        return {7'h00, r2, r1, 3'h0, 5'h03, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ia, ib, ic, id, ie;

    initial begin
        ia = mk(5'd1, 5'd2);
        ib = mk(5'd3, 5'd4);
        ic = mk(5'd5, 5'd6);
        id = mk(5'd7, 5'd8);
        ie = mk(5'd31, 5'd17);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; stall1 = 1'b0; zero1 = 1'b0;
        branch_target = 64'h0; imem_rdata = ia;
        #3;
        chk("rst_addr", imem_addr, 64'h1000);
        chk("rst_valid", {63'h0, if_id_valid}, 64'h0);
        chk("rst_instr", {32'h0, if_id_instr}, 64'h13);
        chk("rst_pc", if_id_pc, 64'h0);
        chk("rst_cnt", {32'h0, stall_count}, 64'h0);
        #9 rst = 1'b0;

        // Free fetch
        step();
        chk("f1_pc", if_id_pc, 64'h1000);
        chk("f1_instr", {32'h0, if_id_instr}, {32'h0, ia});
        chk("f1_valid", {63'h0, if_id_valid}, 64'h1);
        chk("f1_rs1", {59'h0, if_id_rs1}, 64'd1);
        chk("f1_rs2", {59'h0, if_id_rs2}, 64'd2);
        chk("f1_addr", imem_addr, 64'h1004);
        imem_rdata = ib;
        step();
        chk("f2_pc", if_id_pc, 64'h1004);
        chk("f2_instr", {32'h0, if_id_instr}, {32'h0, ib});
        chk("f2_addr", imem_addr, 64'h1008);
        imem_rdata = ic;

        // Load-use stall for two cycles
        stall = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            chk("st_pc", if_id_pc, 64'h1004);
            chk("st_instr", {32'h0, if_id_instr}, {32'h0, ib});
            chk("st_addr", imem_addr, 64'h1008);
            chk("st_cnt", {32'h0, stall_count}, 64'(i));
        end
        stall = 1'b0;
        step();
        chk("f3_pc", if_id_pc, 64'h1008);
        chk("f3_instr", {32'h0, if_id_instr}, {32'h0, ic});
        chk("f3_rs1", {59'h0, if_id_rs1}, 64'd5);
        chk("f3_addr", imem_addr, 64'h100C);

        // Flush with misaligned target
        flush = 1'b1; branch_target = 64'h2003; imem_rdata = id;
        step();
        chk("fl_addr", imem_addr, 64'h2000);
        chk("fl_valid", {63'h0, if_id_valid}, 64'h0);
        chk("fl_instr", {32'h0, if_id_instr}, 64'h13);
        chk("fl_pc", if_id_pc, 64'h0);
        chk("fl_rs1", {59'h0, if_id_rs1}, 64'h0);
        chk("fl_rs2", {59'h0, if_id_rs2}, 64'h0);
        flush = 1'b0;
        step();
        chk("f4_pc", if_id_pc, 64'h2000);
        chk("f4_valid", {63'h0, if_id_valid}, 64'h1);

        // Flush and stall together
        flush = 1'b1; stall = 1'b1; branch_target = 64'h3000;
        step();
        chk("fs_addr", imem_addr, 64'h3000);
        chk("fs_valid", {63'h0, if_id_valid}, 64'h0);
        chk("fs_rs2", {59'h0, if_id_rs2}, 64'h0);
        chk("fs_cnt", {32'h0, stall_count}, 64'd2);
        stall = 1'b0;

        // PC wrap
        branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        chk("wr_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        flush = 1'b0; imem_rdata = ie;
        step();
        chk("wr_addr1", imem_addr, 64'h0);
        chk("wr_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_instr", {32'h0, if_id_instr}, {32'h0, ie});
        chk("wr_rs1", {59'h0, if_id_rs1}, 64'd31);
        chk("wr_rs2", {59'h0, if_id_rs2}, 64'd17);

        // Async reset in the middle of a stall
        stall = 1'b1;
        step();
        chk("ms_cnt", {32'h0, stall_count}, 64'd3);
        #3 rst = 1'b1;
        #1;
        chk("ar_addr", imem_addr, 64'h1000);
        chk("ar_valid", {63'h0, if_id_valid}, 64'h0);
        chk("ar_instr", {32'h0, if_id_instr}, 64'h13);
        chk("ar_cnt", {32'h0, stall_count}, 64'h0);
        chk("ar_rs1", {59'h0, if_id_rs1}, 64'h0);
        stall = 1'b0; imem_rdata = ia;
        #2 rst = 1'b0;
        step();
        chk("rr_pc", if_id_pc, 64'h1000);
        chk("rr_instr", {32'h0, if_id_instr}, {32'h0, ia});
        chk("rr_addr", imem_addr, 64'h1004);

        // Saturation on the 2-bit counter instance
        stall1 = 1'b1;
        step(); chk("sat1", {62'h0, u1_cnt}, 64'd1);
        step(); chk("sat2", {62'h0, u1_cnt}, 64'd2);
        step(); chk("sat3", {62'h0, u1_cnt}, 64'd3);
        step(); chk("sat4", {62'h0, u1_cnt}, 64'd3);
        chk("sat_hold", u1_addr, 64'h4);
        stall1 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
